// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: single-cycle MULT/MULTU and a
// 32-cycle restoring radix-2 DIV/DIVU that stalls the pipeline through busyE.
module mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             mthiE,
    input  logic             mtloE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busyE
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic {StIdle, StDiv} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
    logic             neg_quo_q, neg_rem_q, dvz_q;

    logic             start_eff, move_eff;
    logic             is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic [WIDTH:0]   shifted, diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin;

    assign busyE = (state_q == StDiv);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        start_eff = startE & ~flushE & ~busyE;
        // A start in the same cycle takes priority over an mthi/mtlo.
        move_eff  = ~flushE & ~busyE & ~start_eff;
        is_div    = opE[1];
        is_signed = ~opE[0];
        a_neg     = is_signed & srcaE[WIDTH-1];
        b_neg     = is_signed & srcbE[WIDTH-1];
        a_mag     = a_neg ? (~srcaE + 1'b1) : srcaE;
        b_mag     = b_neg ? (~srcbE + 1'b1) : srcbE;
        a_ext     = {{WIDTH{a_neg}}, srcaE};
        b_ext     = {{WIDTH{b_neg}}, srcbE};
        product   = a_ext * b_ext;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr_q};
        take    = ~diff[WIDTH];
        rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], take};
        quo_fin = dvz_q ? '1 : (neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt);
        rem_fin = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_eff) begin
                        if (is_div) begin
                            state_q   <= StDiv;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            dvsr_q    <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            dvz_q     <= (srcbE == '0);
                        end else begin
                            hi_q <= product[2*WIDTH-1:WIDTH];
                            lo_q <= product[WIDTH-1:0];
                        end
                    end else if (move_eff) begin
                        if (mthiE) hi_q <= srcaE;
                        if (mtloE) lo_q <= srcaE;
                    end
                end
                StDiv: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        hi_q    <= rem_fin;
                        lo_q    <= quo_fin;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for mdu: multiplies, divides, corner cases,
// busy-time ignores, flush, moves and asynchronous reset.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        flushE, mthiE, mtloE;
    logic [31:0] hi, lo;
    logic        busyE;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [63:0] hilo;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] cur;

    mdu #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .opE    (opE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .flushE (flushE),
        .mthiE  (mthiE),
        .mtloE  (mtloE),
        .hi     (hi),
        .lo     (lo),
        .busyE  (busyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sbv;
        sa  = a;
        sbv = b;
        case (op)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b11) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sbv), 32'(sa / sbv)};
            end
        endcase
    endfunction

    task automatic compare_top();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed=output expected=no pending entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, {hi, lo}, e.hilo);
            cur = e.hilo;
        end
    endtask

    // Called and returning at a falling edge.
    task automatic do_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        sb.push_back('{tag: tag, hilo: exp});
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
        check({tag, " busy"}, 64'(busyE), 64'd0);
        compare_top();
    endtask

    task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag, input int poke);
        int   n;
        logic stable;
        sb.push_back('{tag: tag, hilo: exp});
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
        n = 0;
        stable = 1'b1;
        while (busyE === 1'b1 && n < 100) begin
            if ({hi, lo} !== cur) stable = 1'b0;
            n++;
            startE = (n == poke);
            mthiE  = (n == poke);
            if (n == poke) begin
                opE = 2'b00; srcaE = 32'hDEAD_BEEF; srcbE = 32'h3;
            end
            @(negedge clk);
            startE = 1'b0;
            mthiE  = 1'b0;
        end
        check({tag, " busy cycles"}, 64'(n), 64'd32);
        check({tag, " hilo stable"}, 64'(stable), 64'd1);
        compare_top();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic        quiet;
        reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        flushE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
        cur = '0;
        @(negedge clk);
        check("reset hilo", {hi, lo}, 64'h0);
        check("reset busy", 64'(busyE), 64'd0);
        reset = 1'b0;

        do_mul(2'b00, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, "mult -2*3");
        do_mul(2'b01, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, "multu");
        do_mul(2'b00, 32'h8000_0000, 32'h8000_0000, model(2'b00, 32'h8000_0000, 32'h8000_0000),
               "mult minint^2");

        do_div(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div -7/2", -1);
        do_div(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, "divu 100/7", -1);
        do_div(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu 5/0", -1);
        do_div(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div -5/0", -1);
        do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div min/-1", -1);
        do_div(2'b10, 32'd7, 32'hFFFF_FFFE, model(2'b10, 32'd7, 32'hFFFF_FFFE), "div 7/-2", -1);

        for (int i = 0; i < 4; i++) begin
            ra  = $urandom;
            rb  = $urandom_range(1, 5000);
            if (i[0]) rb = ~rb + 1'b1;
            rop = i[1] ? 2'b11 : 2'b10;
            do_div(rop, ra, rb, model(rop, ra, rb), "rand div", -1);
        end

        // MULT start and mthi pulsed mid-divide must both be ignored.
        do_div(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, "divu with busy pokes", 10);

        // Reset mid-divide aborts without waiting for a clock edge.
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
        @(negedge clk);
        startE = 1'b0;
        repeat (15) @(negedge clk);
        check("busy before abort", 64'(busyE), 64'd1);
        reset = 1'b1;
        #1;
        check("async reset busy", 64'(busyE), 64'd0);
        check("async reset hilo", {hi, lo}, 64'h0);
        cur = '0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busyE !== 1'b0 || {hi, lo} !== cur) quiet = 1'b0;
        end
        check("no write after abort", 64'(quiet), 64'd1);

        // Requests during reset are ignored; first edge after release accepts a start.
        do_mul(2'b01, 32'd9, 32'd9, 64'd81, "mult before reset");
        reset = 1'b1;
        startE = 1'b1; opE = 2'b00; srcaE = 32'd6; srcbE = 32'd7; mthiE = 1'b1; mtloE = 1'b1;
        @(negedge clk);
        cur = '0;
        check("ignored in reset", {hi, lo}, cur);
        mthiE = 1'b0; mtloE = 1'b0;
        reset = 1'b0;
        do_mul(2'b00, 32'd6, 32'd7, 64'd42, "mult after release");

        // Flushed requests change nothing.
        startE = 1'b1; flushE = 1'b1; opE = 2'b10; srcaE = 32'd50; srcbE = 32'd5;
        mthiE = 1'b1;
        @(negedge clk);
        check("flushed busy", 64'(busyE), 64'd0);
        check("flushed hilo", {hi, lo}, cur);
        startE = 1'b0; flushE = 1'b0; mthiE = 1'b0;

        mtloE = 1'b1; srcaE = 32'h1234;
        sb.push_back('{tag: "mtlo", hilo: {cur[63:32], 32'h1234}});
        @(negedge clk);
        mtloE = 1'b0;
        compare_top();
        mthiE = 1'b1; srcaE = 32'hCAFE_0001;
        sb.push_back('{tag: "mthi", hilo: {32'hCAFE_0001, cur[31:0]}});
        @(negedge clk);
        mthiE = 1'b0;
        compare_top();

        // Start beats a simultaneous mtlo.
        mtloE = 1'b1;
        do_mul(2'b01, 32'd3, 32'd4, 64'd12, "start wins over mtlo");
        mtloE = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is required to work.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 startE  input  1  E-stage multiply/divide instruction valid this cycle.
REQ-005 opE  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srcaE  input  WIDTH  rs operand (multiplicand or dividend), already forwarded.
REQ-007 srcbE  input  WIDTH  rt operand (multiplier or divisor), already forwarded.
REQ-008 flushE  input  1  E stage holds a bubble this cycle; suppresses startE, mthiE and mtloE.
REQ-009 mthiE  input  1  write srcaE to HI.
REQ-010 mtloE  input  1  write srcaE to LO.
REQ-011 hi  output  WIDTH  current HI register.
REQ-012 lo  output  WIDTH  current LO register.
REQ-013 busyE  output  1  divide in progress; the hazard unit stalls F/D/E on it.

Function
REQ-014 An effective start SHALL be startE & ~flushE & ~busyE; startE while busyE is high SHALL be ignored.
REQ-015 MULT/MULTU SHALL produce a 64-bit signed/unsigned product {HI,LO} written on the edge ending the start cycle; busyE SHALL stay low.
REQ-016 The FSM SHALL have exactly two states, IDLE and DIV; an effective DIV/DIVU start SHALL move IDLE->DIV and latch the operand magnitudes, the signs and the op.
REQ-017 busyE SHALL equal (state==DIV), driven from registered state only, never from inputs.
REQ-018 The divider SHALL be restoring radix-2, one quotient bit per cycle, with a 5-bit iteration counter cleared on start.
REQ-019 busyE SHALL be high for exactly 32 cycles after the start edge; on the 32nd DIV edge, HI/LO SHALL be written, state SHALL return to IDLE, and the counter SHALL wrap to 0.
REQ-020 Division SHALL write the quotient to LO and the remainder to HI.
REQ-021 For DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend; sign correction SHALL be applied in the final write.
REQ-022 Divide by zero SHALL complete in 32 cycles with LO=32'hFFFFFFFF and HI=dividend as presented, for both DIV and DIVU.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-024 An effective mthiE/mtloE (~flushE & ~busyE) SHALL update HI/LO on the next edge; mthiE/mtloE while busyE is high SHALL be ignored.
REQ-025 If an effective start and an effective mthiE/mtloE occur in the same cycle, the start SHALL win and the move SHALL be dropped.
REQ-026 HI/LO SHALL be stable between writes; no partial divider state SHALL be visible on hi/lo while busyE is high.
REQ-027 After the completion edge, a new start on the immediately following cycle SHALL be accepted (back-to-back divides with no idle gap).

Reset
REQ-028 reset high SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busyE=0 and clear divider datapath registers.
REQ-029 Reset asserted mid-divide SHALL abort it; no result SHALL be written after release.
REQ-030 During reset, startE, mthiE and mtloE SHALL be ignored; the first effective start is accepted on the first edge after reset deasserts.

Verification
REQ-031 MULT srcaE=32'hFFFFFFFE (-2), srcbE=3 -> next cycle {hi,lo}=64'hFFFFFFFF_FFFFFFFA; MULTU with the same operands -> hi=2, lo=32'hFFFFFFFA; busyE never high.
REQ-032 DIV srcaE=-7, srcbE=2 -> busyE high for 32 cycles, then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-033 DIVU 5/0 -> after 32 cycles lo=32'hFFFFFFFF, hi=5; DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
REQ-034 Start DIV, then pulse startE (MULT) and mthiE at cycle 10 of busy -> both ignored; final hi/lo equal the divide result only.
REQ-035 Assert reset at busy cycle 16 -> busyE, hi and lo go to 0 without waiting for a clock edge; after release, 40 idle cycles show no write.
REQ-036 startE with flushE high -> no state change; mtloE=1 with srcaE=32'h1234 and busyE low -> lo=32'h1234 next cycle; startE and mtloE together -> mtlo dropped.
